// File: rtl/fir_sched_pkg.sv
// Shared types and constants for the band-multiplexed FIR scheduler.
// Holds the FSM encoding, pipeline/format constants and saturation bound helpers.
package fir_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_OUT
    } state_t;

    localparam int DRAIN_CYC  = 3;
    localparam int FRAC_SHIFT = 15;

    function automatic longint sat_max(input int dw);
        return (longint'(1) <<< (dw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Multiply-accumulate back end: product register, accumulator with clear,
// Q1.15 rescale and saturation. Ports: i_vld/i_first/i_samp/i_coef in, o_res/o_sat out.
module fir_mac_unit #(
    parameter int DW    = 24,
    parameter int CW    = 16,
    parameter int ACC_W = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_vld,
    input  logic                 i_first,
    input  logic signed [DW-1:0] i_samp,
    input  logic signed [CW-1:0] i_coef,
    output logic signed [DW-1:0] o_res,
    output logic                 o_sat
);
    import fir_sched_pkg::*;

    localparam logic signed [ACC_W-1:0] L_MAX = ACC_W'(sat_max(DW));
    localparam logic signed [ACC_W-1:0] L_MIN = ACC_W'(sat_min(DW));

    logic signed [DW+CW-1:0] r_prod;
    logic                    r_pvld;
    logic                    r_pfirst;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_shift;

    assign w_prod_ext = ACC_W'(r_prod);
    assign w_shift    = r_acc >>> FRAC_SHIFT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod   <= '0;
            r_pvld   <= 1'b0;
            r_pfirst <= 1'b0;
            r_acc    <= '0;
        end else begin
            r_prod   <= (DW+CW)'(i_samp) * (DW+CW)'(i_coef);
            r_pvld   <= i_vld;
            r_pfirst <= i_first;
            // First product of a band replaces the previous band's sum.
            if (r_pvld) begin
                r_acc <= r_pfirst ? w_prod_ext : r_acc + w_prod_ext;
            end
        end
    end

    always_comb begin
        o_res = w_shift[DW-1:0];
        o_sat = 1'b0;
        if (w_shift > L_MAX) begin
            o_res = L_MAX[DW-1:0];
            o_sat = 1'b1;
        end else if (w_shift < L_MIN) begin
            o_res = L_MIN[DW-1:0];
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/fir_band_scheduler.sv
// Shares one MAC across N_BANDS FIR bands over a circular sample buffer.
// Ports: sample in (sample_valid/audio_in/ready), coef RAM (coef_rd_en/addr/data), results (band_*/done), overrun.
module fir_band_scheduler #(
    parameter int N_TAPS  = 255,
    parameter int N_BANDS = 4,
    parameter int DW      = 24,
    parameter int CW      = 16,
    parameter int ACC_W   = 48,
    parameter int CA_W    = $clog2(N_BANDS * N_TAPS),
    parameter int TW      = $clog2(N_TAPS),
    parameter int BW      = (N_BANDS > 1) ? $clog2(N_BANDS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          sample_valid,
    input  logic [DW-1:0] audio_in,
    output logic          ready,
    output logic          coef_rd_en,
    output logic [CA_W-1:0] coef_addr,
    input  logic [CW-1:0] coef_data,
    output logic          band_valid,
    output logic [BW-1:0] band_idx,
    output logic [DW-1:0] band_out,
    output logic          band_sat,
    output logic          done,
    output logic          overrun,
    input  logic          clear_ovr
);
    import fir_sched_pkg::*;

    state_t          r_state;
    state_t          w_next;
    logic [DW-1:0]   r_buf [N_TAPS];
    logic [TW-1:0]   r_wptr;
    logic [TW-1:0]   r_tap;
    logic [BW-1:0]   r_band;
    logic [1:0]      r_dcnt;
    logic [DW-1:0]   r_sample;
    logic            r_ready;
    logic            r_ovr;
    logic            r_s1_v;
    logic            r_s1_first;
    logic [DW-1:0]   r_s1_samp;
    logic            r_m_v;
    logic            r_m_first;
    logic [DW-1:0]   r_m_samp;
    logic [CW-1:0]   r_m_coef;

    logic            w_accept;
    logic            w_last_tap;
    logic            w_last_drain;
    logic            w_last_band;
    logic [TW-1:0]   w_wnext;
    logic [TW-1:0]   w_ridx;
    logic [DW-1:0]   w_res;
    logic            w_sat;

    assign w_accept     = sample_valid & enable & r_ready;
    assign w_last_tap   = (r_tap == TW'(N_TAPS - 1));
    assign w_last_drain = (r_dcnt == 2'(DRAIN_CYC - 1));
    assign w_last_band  = (r_band == BW'(N_BANDS - 1));
    assign w_wnext      = (r_wptr == TW'(N_TAPS - 1)) ? '0 : r_wptr + 1'b1;
    // Modulo distance back from the newest sample; exact for any pointer.
    assign w_ridx = (r_wptr >= r_tap) ? r_wptr - r_tap
                                      : r_wptr - r_tap + TW'(N_TAPS);

    assign ready   = r_ready;
    assign overrun = r_ovr;

    always_comb begin
        w_next     = r_state;
        coef_rd_en = 1'b0;
        coef_addr  = '0;
        band_valid = 1'b0;
        band_idx   = '0;
        band_out   = '0;
        band_sat   = 1'b0;
        done       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_LOAD;
            end
            S_LOAD: w_next = S_RUN;
            S_RUN: begin
                coef_rd_en = 1'b1;
                coef_addr  = CA_W'(r_band) * CA_W'(N_TAPS) + CA_W'(r_tap);
                if (w_last_tap) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_last_drain) w_next = S_OUT;
            end
            S_OUT: begin
                band_valid = 1'b1;
                band_idx   = r_band;
                band_out   = w_res;
                band_sat   = w_sat;
                done       = w_last_band;
                w_next     = w_last_band ? S_IDLE : S_RUN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b0;
            r_ovr      <= 1'b0;
            r_wptr     <= '0;
            r_tap      <= '0;
            r_band     <= '0;
            r_dcnt     <= '0;
            r_sample   <= '0;
            r_s1_v     <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_samp  <= '0;
            r_m_v      <= 1'b0;
            r_m_first  <= 1'b0;
            r_m_samp   <= '0;
            r_m_coef   <= '0;
            for (int i = 0; i < N_TAPS; i++) r_buf[i] <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == S_IDLE);
            if (w_accept) r_sample <= audio_in;
            if (clear_ovr) begin
                r_ovr <= 1'b0;
            end else if (sample_valid && !r_ready) begin
                r_ovr <= 1'b1;
            end
            if (r_state == S_LOAD) begin
                r_buf[w_wnext] <= r_sample;
                r_wptr         <= w_wnext;
            end
            if (r_state == S_RUN) r_tap <= w_last_tap ? '0 : r_tap + 1'b1;
            if (r_state == S_DRAIN) r_dcnt <= w_last_drain ? '0 : r_dcnt + 1'b1;
            if (r_state == S_OUT) r_band <= w_last_band ? '0 : r_band + 1'b1;
            r_s1_v     <= (r_state == S_RUN);
            r_s1_first <= (r_state == S_RUN) && (r_tap == '0);
            r_s1_samp  <= r_buf[w_ridx];
            r_m_v      <= r_s1_v;
            r_m_first  <= r_s1_first;
            r_m_samp   <= r_s1_samp;
            // Coefficient bus is only meaningful one cycle after a read.
            r_m_coef   <= r_s1_v ? coef_data : '0;
        end
    end

    fir_mac_unit #(
        .DW    (DW),
        .CW    (CW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_vld   (r_m_v),
        .i_first (r_m_first),
        .i_samp  (r_m_samp),
        .i_coef  (r_m_coef),
        .o_res   (w_res),
        .o_sat   (w_sat)
    );

endmodule

// File: tb/tb_fir_band_scheduler.sv
// Self-checking bench for fir_band_scheduler (8 taps, 4 bands).
// Directed scenarios plus random coefficient/sample runs against a sum-of-products model.
module tb_fir_band_scheduler;

    localparam int NT = 8;
    localparam int NB = 4;
    localparam int DW = 24;
    localparam int CW = 16;
    localparam int CAW = 5;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          sample_valid;
    logic [DW-1:0] audio_in;
    logic          ready;
    logic          coef_rd_en;
    logic [CAW-1:0] coef_addr;
    logic [CW-1:0] coef_data;
    logic          band_valid;
    logic [1:0]    band_idx;
    logic [DW-1:0] band_out;
    logic          band_sat;
    logic          done;
    logic          overrun;
    logic          clear_ovr;

    fir_band_scheduler #(
        .N_TAPS  (NT),
        .N_BANDS (NB),
        .DW      (DW),
        .CW      (CW),
        .ACC_W   (48)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_valid (sample_valid),
        .audio_in     (audio_in),
        .ready        (ready),
        .coef_rd_en   (coef_rd_en),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .band_valid   (band_valid),
        .band_idx     (band_idx),
        .band_out     (band_out),
        .band_sat     (band_sat),
        .done         (done),
        .overrun      (overrun),
        .clear_ovr    (clear_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic signed [CW-1:0] cmem [NB*NT];

    // Coefficient RAM, one-cycle latency; garbage when no read was issued.
    always @(posedge clk) begin
        if (coef_rd_en) coef_data <= cmem[coef_addr];
        else coef_data <= 16'($urandom);
    end

    int     n_cmp;
    int     n_bad;
    longint hist [NT];
    longint e_out [NB];
    longint e_sat [NB];
    longint obs_out [NB];
    longint obs_sat [NB];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void hist_clear();
        for (int k = 0; k < NT; k++) hist[k] = 0;
    endfunction

    // Newest sample at position 0, oldest falls off the end.
    function automatic void model_push(input logic signed [DW-1:0] x);
        for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = longint'(x);
        for (int b = 0; b < NB; b++) begin
            longint acc;
            longint sh;
            acc = 0;
            for (int k = 0; k < NT; k++) acc += longint'(cmem[b*NT+k]) * hist[k];
            sh = acc >>> 15;
            e_sat[b] = 0;
            if (sh > 64'sd8388607) begin
                sh = 64'sd8388607;
                e_sat[b] = 1;
            end else if (sh < -64'sd8388608) begin
                sh = -64'sd8388608;
                e_sat[b] = 1;
            end
            e_out[b] = sh;
        end
    endfunction

    task automatic run_sample(input logic signed [DW-1:0] x, input bit inj_ovr);
        int b;
        bit is_out;
        audio_in     = x;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        model_push(x);
        for (int c = 1; c <= 50; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            is_out = (c >= 13) && (c <= 49) && ((c - 13) % 12 == 0);
            b = (c - 13) / 12;
            chk("band_valid", longint'(band_valid), longint'(is_out));
            chk("done", longint'(done), longint'(c == 49));
            chk("ready", longint'(ready), longint'(c == 50));
            if (is_out) begin
                obs_out[b] = longint'($signed(band_out));
                obs_sat[b] = longint'(band_sat);
                chk("band_idx", longint'(band_idx), longint'(b));
                chk("band_out", obs_out[b], e_out[b]);
                chk("band_sat", obs_sat[b], e_sat[b]);
            end
            if (inj_ovr && c == 4) begin
                sample_valid = 1'b1;
                audio_in     = DW'($urandom);
            end else if (c == 5) begin
                sample_valid = 1'b0;
            end
        end
    endtask

    initial begin
        bit seen;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        enable = 1'b1;
        sample_valid = 1'b0;
        audio_in = '0;
        clear_ovr = 1'b0;
        for (int i = 0; i < NB*NT; i++) cmem[i] = '0;
        hist_clear();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", longint'(ready), 0);
        chk("rst_valid", longint'(band_valid), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_ovr", longint'(overrun), 0);
        chk("rst_rden", longint'(coef_rd_en), 0);
        chk("rst_out", longint'(band_out), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("ready_idle", longint'(ready), 1);

        // Impulse
        cmem[0] = 16'sh7FFF;
        run_sample(24'sh100000, 1'b0);
        chk("impulse_b0", obs_out[0], 64'h0FFFE0);
        chk("impulse_b1", obs_out[1], 0);

        // Overrun while busy
        run_sample(24'sh100000, 1'b1);
        chk("ovr_set", longint'(overrun), 1);
        chk("impulse2_b0", obs_out[0], 64'h0FFFE0);
        clear_ovr = 1'b1;
        @(posedge clk);
        #1;
        clear_ovr = 1'b0;
        chk("ovr_clr", longint'(overrun), 0);

        // Disabled input is ignored
        enable = 1'b0;
        sample_valid = 1'b1;
        audio_in = 24'h123456;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (!ready || band_valid || coef_rd_en) seen = 1;
        end
        chk("disabled_ignored", longint'(seen), 0);
        chk("disabled_no_ovr", longint'(overrun), 0);
        enable = 1'b1;

        // Saturation
        for (int i = 0; i < NB*NT; i++) cmem[i] = 16'sh7FFF;
        for (int s = 0; s < NT; s++) run_sample(24'sh7FFFFF, 1'b0);
        for (int b = 0; b < NB; b++) begin
            chk("sat_out", obs_out[b], 64'h7FFFFF);
            chk("sat_flag", obs_sat[b], 1);
        end

        // Buffer wrap
        for (int i = 0; i < NB*NT; i++) cmem[i] = '0;
        cmem[NT+7] = 16'sh4000;
        for (int s = 1; s <= 20; s++) run_sample(DW'(2 * s), 1'b0);
        chk("wrap_b1", obs_out[1], 13);

        // Random coefficients and samples
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NB*NT; i++) cmem[i] = 16'($urandom);
            run_sample(DW'($urandom), 1'b0);
        end

        // Reset in the middle of RUN
        audio_in = 24'h0ABCDE;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("midrun_rden", longint'(coef_rd_en), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", longint'(band_valid), 0);
        chk("abort_done", longint'(done), 0);
        chk("abort_rden", longint'(coef_rd_en), 0);
        chk("abort_ready", longint'(ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (band_valid || done) seen = 1;
        end
        chk("abort_no_result", longint'(seen), 0);
        hist_clear();
        for (int i = 0; i < NB*NT; i++) cmem[i] = 16'sh1000;
        run_sample(24'sh040000, 1'b0);
        chk("fresh_b3", obs_out[3], longint'(24'sh040000 >>> 3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
